// File: rtl/usb_tx_sched.sv
// USB transmit packet scheduler: arbitrates token/data/handshake sources, drives the serial encoder.
// Optional macro USB_TX_RR_EN: round-robin between token and data (handshake stays highest priority).
module usb_tx_sched #(
    parameter int IPG     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_req,
    input  logic        dat_req,
    input  logic        hs_req,
    input  logic [18:0] tok_pkt,
    input  logic [71:0] dat_pkt,
    input  logic [7:0]  hs_pid,
    output logic        tok_gnt,
    output logic        dat_gnt,
    output logic        hs_gnt,
    output logic        tok_done,
    output logic        dat_done,
    output logic        hs_done,
    output logic        enc_start,
    output logic [1:0]  enc_type,
    output logic [71:0] enc_pkt,
    input  logic        enc_done,
    output logic        enc_abort,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_TOK  = 2'b01;
    localparam logic [1:0] T_DAT  = 2'b10;
    localparam logic [1:0] T_HS   = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(IPG - 1);

    state_t      state;
    logic [1:0]  owner;
    logic [7:0]  tmo_cnt;
    logic [3:0]  gap_cnt;
    logic [1:0]  win;
    logic [71:0] win_pkt;
    logic        wait_done;
    logic        wait_tmo;
`ifdef USB_TX_RR_EN
    logic        rr_dat_pref;
`endif

    // Handshake always first; token/data either fixed or alternating.
    always_comb begin
        win = T_NONE;
        if (hs_req)
            win = T_HS;
`ifdef USB_TX_RR_EN
        else if (tok_req && dat_req)
            win = rr_dat_pref ? T_DAT : T_TOK;
`endif
        else if (tok_req)
            win = T_TOK;
        else if (dat_req)
            win = T_DAT;
    end

    always_comb begin
        case (win)
            T_TOK:   win_pkt = {53'd0, tok_pkt};
            T_DAT:   win_pkt = dat_pkt;
            T_HS:    win_pkt = {64'd0, hs_pid};
            default: win_pkt = '0;
        endcase
    end

    // enc_done beats a coincident timeout.
    assign wait_done   = (state == WAIT) && enc_done;
    assign wait_tmo    = (state == WAIT) && !enc_done && (tmo_cnt == TMO_LAST);

    assign tok_done    = wait_done && (owner == T_TOK);
    assign dat_done    = wait_done && (owner == T_DAT);
    assign hs_done     = wait_done && (owner == T_HS);
    assign enc_abort   = wait_tmo;
    assign timeout_err = wait_tmo;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= T_NONE;
            enc_type  <= T_NONE;
            enc_pkt   <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            tok_gnt   <= 1'b0;
            dat_gnt   <= 1'b0;
            hs_gnt    <= 1'b0;
            enc_start <= 1'b0;
`ifdef USB_TX_RR_EN
            rr_dat_pref <= 1'b0;
`endif
        end else begin
            tok_gnt   <= 1'b0;
            dat_gnt   <= 1'b0;
            hs_gnt    <= 1'b0;
            enc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != T_NONE) begin
                        state     <= START;
                        owner     <= win;
                        enc_type  <= win;
                        enc_pkt   <= win_pkt;
                        tok_gnt   <= (win == T_TOK);
                        dat_gnt   <= (win == T_DAT);
                        hs_gnt    <= (win == T_HS);
                        enc_start <= 1'b1;
`ifdef USB_TX_RR_EN
                        if (win == T_TOK)
                            rr_dat_pref <= 1'b1;
                        else if (win == T_DAT)
                            rr_dat_pref <= 1'b0;
`endif
                    end
                end
                START: begin
                    state   <= WAIT;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (enc_done || (tmo_cnt == TMO_LAST)) begin
                        owner    <= T_NONE;
                        enc_type <= T_NONE;
                        enc_pkt  <= '0;
                        tmo_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= (IPG == 0) ? IDLE : GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
